// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered pcpu instruction-decode stage
// Latches one instruction per handshake and drives the control word; memory ops run a req/ack FSM with timeout.
module decode_stage #(
    parameter int REGS         = 8,
    parameter int RSW          = $clog2(REGS),
    parameter int INSTR_W      = 7 + 3 * RSW,
    parameter int FLAGS_W      = 5,
    parameter int MEM_TIMEOUT  = 255,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [FLAGS_W-1:0] i_flags,
    input  logic               i_flush,
    input  logic               i_mem_ack,
    output logic               o_out_valid,
    output logic [3:0]         o_alu_mode,
    output logic [RSW-1:0]     o_reg_l_sel,
    output logic [RSW-1:0]     o_reg_r_sel,
    output logic [REGS-1:0]    o_gp_reg_ie,
    output logic               o_alu_r_imm,
    output logic               o_alu_cin,
    output logic               o_alu_flags_ie,
    output logic               o_reg_in_mem,
    output logic               o_reg_sr_in,
    output logic               o_sr_ie,
    output logic               o_sr_pc_over,
    output logic               o_pc_ie,
    output logic               o_pc_inc,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic               o_illegal_instr,
    output logic               o_bus_fault
);
    localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    localparam logic [3:0] MODE_ADD = 4'h0, MODE_ADC = 4'h1, MODE_SUB = 4'h2, MODE_SBC = 4'h3;
    localparam logic [3:0] MODE_AND = 4'h4, MODE_OR = 4'h5, MODE_XOR = 4'h6, MODE_NOT = 4'h7;
    localparam logic [3:0] MODE_SHL = 4'h8, MODE_SHR = 4'h9, MODE_MUL = 4'hA, MODE_DIV = 4'hB;
    localparam logic [3:0] MODE_PASS_L = 4'hC, MODE_PASS_R = 4'hD, MODE_INC = 4'hE, MODE_DEC = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_live;
    logic [CNT_W-1:0]   r_cnt;
    logic [INSTR_W-1:0] r_instr;
    logic [3:0]         r_flags;

    logic [6:0]      w_op;
    logic [RSW-1:0]  w_tg, w_fo, w_so;
    logic [3:0]      w_cond;
    logic [REGS-1:0] w_onehot;
    logic            w_is_load, w_is_store, w_in_mem, w_accept, w_timeout, w_abort, w_jmp_en;
    logic            w_unused_flags;

    logic [3:0]     w_d_mode;
    logic [RSW-1:0] w_d_l_sel, w_d_r_sel;
    logic           w_d_r_imm, w_d_cin, w_d_fie, w_d_wr, w_d_sr_in, w_d_sr_ie, w_d_jmp, w_d_jal, w_d_legal;

    assign w_op       = r_instr[6:0];
    assign w_tg       = r_instr[7 +: RSW];
    assign w_fo       = r_instr[7 + RSW +: RSW];
    assign w_so       = r_instr[7 + 2 * RSW +: RSW];
    assign w_cond     = r_instr[10:7];
    assign w_onehot   = REGS'(1) << w_tg;
    assign w_is_load  = (w_op == 7'h02) || (w_op == 7'h03);
    assign w_is_store = (w_op == 7'h05) || (w_op == 7'h06);
    assign w_in_mem   = (i_instr[6:0] == 7'h02) || (i_instr[6:0] == 7'h03) ||
                        (i_instr[6:0] == 7'h05) || (i_instr[6:0] == 7'h06);
    assign w_accept   = (r_state == S_IDLE) && r_live && i_in_valid && !i_flush;
    assign w_timeout  = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT));
    assign w_abort    = i_flush || i_rst;
    assign w_unused_flags = ^i_flags;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_cnt   <= '0;
            r_instr <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_instr <= i_instr;
                r_flags <= i_flags[3:0];
            end
            // Counts un-acked MEM cycles; idles at zero so every MEM entry starts fresh.
            if (r_state == S_MEM && !i_mem_ack) r_cnt <= r_cnt + CNT_W'(1);
            else                                 r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_in_mem ? S_MEM : S_EXEC;
            S_EXEC: w_state_next = S_IDLE;
            S_MEM:  if (i_mem_ack || w_timeout) w_state_next = (i_mem_ack && w_is_load) ? S_WB : S_IDLE;
            S_WB:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (i_flush) w_state_next = S_IDLE;
    end

    always_comb begin
        w_d_mode = MODE_ADD; w_d_l_sel = w_fo; w_d_r_sel = w_so;
        w_d_r_imm = 1'b0; w_d_cin = 1'b0; w_d_fie = 1'b0; w_d_wr = 1'b0;
        w_d_sr_in = 1'b0; w_d_sr_ie = 1'b0; w_d_jmp = 1'b0; w_d_jal = 1'b0; w_d_legal = 1'b1;
        case (w_op)
            7'h01: begin w_d_mode = MODE_PASS_L; w_d_wr = 1'b1; end
            7'h02: w_d_mode = MODE_PASS_L;
            7'h03: begin w_d_mode = MODE_ADD; w_d_r_imm = 1'b1; end
            7'h04: begin w_d_mode = MODE_PASS_R; w_d_r_imm = 1'b1; w_d_wr = 1'b1; end
            7'h05: begin w_d_mode = MODE_PASS_L; w_d_l_sel = w_tg; w_d_r_sel = w_fo; end
            7'h06: begin w_d_mode = MODE_ADD; w_d_l_sel = w_tg; w_d_r_sel = w_fo; w_d_r_imm = 1'b1; end
            7'h07: begin w_d_mode = MODE_ADD; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h08: begin w_d_mode = MODE_ADC; w_d_cin = r_flags[1]; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h09: begin w_d_mode = MODE_SUB; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h0A: begin w_d_mode = MODE_SBC; w_d_cin = r_flags[1]; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h0B: begin w_d_mode = MODE_AND; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h0C: begin w_d_mode = MODE_OR;  w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h0D: begin w_d_mode = MODE_XOR; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h0E: begin w_d_mode = MODE_PASS_L; w_d_l_sel = w_so; w_d_jmp = 1'b1; end
            7'h0F: begin w_d_mode = MODE_PASS_L; w_d_l_sel = w_so; w_d_jal = 1'b1; w_d_sr_in = 1'b1; w_d_wr = 1'b1; end
            7'h10: begin w_d_mode = MODE_NOT; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h11: begin w_d_mode = MODE_SUB; w_d_fie = 1'b1; end
            7'h13: begin w_d_mode = MODE_SHL; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h14: begin w_d_mode = MODE_SHR; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h15: begin w_d_mode = MODE_ADD; w_d_r_imm = 1'b1; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h16: begin w_d_mode = MODE_SUB; w_d_r_imm = 1'b1; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h17: begin w_d_sr_in = 1'b1; w_d_wr = 1'b1; end
            7'h18: begin w_d_mode = MODE_PASS_L; w_d_sr_ie = 1'b1; end
            7'h19: w_d_mode = MODE_ADD;
            7'h1A: begin w_d_mode = MODE_INC; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h1B: begin w_d_mode = MODE_DEC; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h1C: begin w_d_mode = MODE_MUL; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            7'h1D: begin w_d_mode = MODE_DIV; w_d_fie = 1'b1; w_d_wr = 1'b1; end
            default: w_d_legal = 1'b0;
        endcase
    end

    // Flag bits: 0 Z, 1 C, 2 LT, 3 user.
    always_comb begin
        case (w_cond)
            4'd1:       w_jmp_en = r_flags[1];
            4'd2:       w_jmp_en = r_flags[0];
            4'd3:       w_jmp_en = r_flags[2];
            4'd4:       w_jmp_en = !(r_flags[2] || r_flags[0]);
            4'd5:       w_jmp_en = r_flags[2] || r_flags[0];
            4'd6:       w_jmp_en = !r_flags[2];
            4'd7:       w_jmp_en = !r_flags[0];
            4'd8, 4'd9: w_jmp_en = r_flags[3];
            default:    w_jmp_en = 1'b1;
        endcase
    end

    always_comb begin
        o_in_ready = 1'b0; o_out_valid = 1'b0; o_alu_mode = 4'h0; o_reg_l_sel = '0; o_reg_r_sel = '0;
        o_gp_reg_ie = '0; o_alu_r_imm = 1'b0; o_alu_cin = 1'b0; o_alu_flags_ie = 1'b0;
        o_reg_in_mem = 1'b0; o_reg_sr_in = 1'b0; o_sr_ie = 1'b0; o_sr_pc_over = 1'b0;
        o_pc_ie = 1'b0; o_pc_inc = 1'b0; o_mem_req = 1'b0; o_mem_we = 1'b0;
        o_illegal_instr = 1'b0; o_bus_fault = 1'b0;
        case (r_state)
            S_IDLE: o_in_ready = r_live;
            S_EXEC: begin
                o_out_valid = 1'b1;
                if (!w_d_legal && TRAP_ILLEGAL != 0) begin
                    o_illegal_instr = 1'b1;
                end else begin
                    o_alu_mode = w_d_mode; o_reg_l_sel = w_d_l_sel; o_reg_r_sel = w_d_r_sel;
                    o_alu_r_imm = w_d_r_imm; o_alu_cin = w_d_cin; o_alu_flags_ie = w_d_fie;
                    o_reg_sr_in = w_d_sr_in; o_sr_ie = w_d_sr_ie;
                    o_gp_reg_ie = w_d_wr ? w_onehot : '0;
                    if (w_d_jal) begin
                        o_pc_ie = 1'b1; o_sr_pc_over = 1'b1;
                    end else if (w_d_jmp) begin
                        o_pc_ie = w_jmp_en; o_pc_inc = !w_jmp_en;
                    end else begin
                        o_pc_inc = 1'b1;
                    end
                end
            end
            S_MEM: begin
                o_mem_req = 1'b1; o_mem_we = w_is_store;
                o_alu_mode = w_d_mode; o_reg_l_sel = w_d_l_sel; o_reg_r_sel = w_d_r_sel; o_alu_r_imm = w_d_r_imm;
                // Ack takes priority over a timeout landing in the same cycle; flush/reset beat both.
                if (!w_abort) begin
                    if (i_mem_ack) begin
                        if (w_is_store) begin o_out_valid = 1'b1; o_pc_inc = 1'b1; end
                    end else if (w_timeout) begin
                        o_out_valid = 1'b1; o_bus_fault = 1'b1;
                    end
                end
            end
            S_WB: begin
                o_out_valid = 1'b1; o_reg_in_mem = 1'b1; o_gp_reg_ie = w_onehot; o_pc_inc = 1'b1;
            end
            default: o_in_ready = 1'b0;
        endcase
    end
endmodule
